// File: rtl/ad9228_pkg.sv
// Shared AD9228 serial-link definitions: frame width, idle word and transmitter state encoding.
// Used by both the transmit emulator and the capture side.
package ad9228_pkg;

  localparam int                             AD9228_DATA_WIDTH = 12;
  localparam logic [AD9228_DATA_WIDTH-1:0]   AD9228_IDLE_WORD  = 12'h800;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/ad9228_lvds_tx_emulator.sv
// Transmit-side model of one AD9228 serial LVDS channel: a one-deep hold register feeds a
// frame shift register that drives dout together with the fco frame clock and dco bit clock.
module ad9228_lvds_tx_emulator
  import ad9228_pkg::*;
#(
  parameter int                     DATA_WIDTH = AD9228_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]  IDLE_WORD  = AD9228_IDLE_WORD,
  parameter bit                     MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  dout,
  output logic                  fco,
  output logic                  dco,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int             BW       = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0]  HALF_W   = BW'(DATA_WIDTH / 2);

  tx_state_t             state, state_next;
  logic [BW-1:0]         bit_idx, bit_idx_next;
  logic                  half, half_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full;
  logic                  frame_end, load, accept;
  logic                  run_next;
  logic                  dout_next, fco_next, dco_next, frame_start_next, underrun_next;

  assign frame_end = (state == RUN) && (bit_idx == LAST_BIT) && half;
  assign load      = tx_en && ((state == IDLE) || frame_end);

  // Ready only counts frame_end when that edge actually drains the hold register, so a
  // full hold is never overwritten on a frame_end that returns to IDLE.
  assign s_ready = ~hold_full | (frame_end & tx_en);
  assign accept  = s_valid & s_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a frame in progress always completes before leaving RUN
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (tx_en)              state_next = RUN;
      RUN:     if (frame_end && !tx_en) state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // Counter, shift register and registered-output next values
  always_comb begin
    bit_idx_next = bit_idx;
    half_next    = half;
    shift_next   = shift_q;
    if (state_next == IDLE) begin
      bit_idx_next = '0;
      half_next    = 1'b0;
    end else if (load) begin
      bit_idx_next = '0;
      half_next    = 1'b0;
      shift_next   = hold_full ? hold_q : IDLE_WORD;
    end else if (half) begin
      half_next    = 1'b0;
      bit_idx_next = bit_idx + 1'b1;
      shift_next   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
    end else begin
      half_next    = 1'b1;
    end

    run_next         = (state_next == RUN);
    dout_next        = run_next & (MSB_FIRST ? shift_next[DATA_WIDTH-1] : shift_next[0]);
    fco_next         = run_next & (bit_idx_next < HALF_W);
    dco_next         = run_next & (bit_idx_next[0] ^ half_next);
    frame_start_next = load;
    underrun_next    = load & ~hold_full;
  end

  // Datapath and output registers; the queued word is discarded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx     <= '0;
      half        <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      dout        <= 1'b0;
      fco         <= 1'b0;
      dco         <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      bit_idx     <= bit_idx_next;
      half        <= half_next;
      shift_q     <= shift_next;
      if (accept) begin
        hold_q    <= s_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      dout        <= dout_next;
      fco         <= fco_next;
      dco         <= dco_next;
      frame_start <= frame_start_next;
      underrun    <= underrun_next;
    end
  end

endmodule

// File: tb/tb_ad9228_lvds_tx_emulator.sv
// Scoreboard bench for ad9228_lvds_tx_emulator: stimulus queues expected frames, monitors
// capture each frame's dout/fco/dco/frame_start/underrun waveform and compare.
module tb_ad9228_lvds_tx_emulator;

  localparam int W = 12;

  typedef struct {
    logic [W-1:0] word;
    logic         ur;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         tx_en, s_valid, s_ready, dout, fco, dco, frame_start, underrun;
  logic [W-1:0] s_data;
  logic         tx_en_l, s_valid_l, s_ready_l, dout_l, fco_l, dco_l, frame_start_l, underrun_l;
  logic [W-1:0] s_data_l;

  exp_t         q[$];
  logic [W-1:0] q_lsb[$];
  int           n_cmp = 0;
  int           n_err = 0;

  ad9228_lvds_tx_emulator dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dout(dout), .fco(fco), .dco(dco),
    .frame_start(frame_start), .underrun(underrun)
  );

  ad9228_lvds_tx_emulator #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .tx_en(tx_en_l), .s_data(s_data_l), .s_valid(s_valid_l),
    .s_ready(s_ready_l), .dout(dout_l), .fco(fco_l), .dco(dco_l),
    .frame_start(frame_start_l), .underrun(underrun_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each data bit appears on dout for two clk cycles, MSB first; cycle 0 lands in the top bit.
  function automatic logic [2*W-1:0] expand(input logic [W-1:0] w);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) r = {r[2*W-3:0], w[i], w[i]};
    return r;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w, input bit track);
    bit ok;
    ok      = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    if (track) q.push_back('{word: w, ur: 1'b0});
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = s_ready;
      @(posedge clk);
      @(negedge clk);
    end
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_frame_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = frame_start;
    end
    check("frame_start_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dout"},        32'(dout),        32'd0);
    check({tag, "_fco"},         32'(fco),         32'd0);
    check({tag, "_dco"},         32'(dco),         32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_underrun"},    32'(underrun),    32'd0);
    check({tag, "_s_ready"},     32'(s_ready),     32'd1);
  endtask

  // Main monitor: one expectation popped per frame_start, whole frame compared at its end
  initial begin : monitor
    exp_t           e;
    logic [2*W-1:0] v_dout, v_fco, v_dco, v_fs, v_ur;
    int             cyc;
    bit             just_ended;
    cyc        = -1;
    just_ended = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc        = -1;
        just_ended = 1'b0;
      end else begin
        if (just_ended) begin
          just_ended = 1'b0;
          check("contiguous_start", 32'(frame_start), 32'(q.size() != 0));
        end
        if (cyc < 0 && frame_start) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: frame_start=1 with no queued word (t=%0t)", $time);
          end else begin
            e      = q.pop_front();
            cyc    = 0;
            v_dout = '0; v_fco = '0; v_dco = '0; v_fs = '0; v_ur = '0;
          end
        end
        if (cyc >= 0) begin
          v_dout = {v_dout[2*W-2:0], dout};
          v_fco  = {v_fco[2*W-2:0],  fco};
          v_dco  = {v_dco[2*W-2:0],  dco};
          v_fs   = {v_fs[2*W-2:0],   frame_start};
          v_ur   = {v_ur[2*W-2:0],   underrun};
          cyc++;
          if (cyc == 2 * W) begin
            check("frame_dout",        32'(v_dout), 32'(expand(e.word)));
            check("frame_fco",         32'(v_fco),  32'h00FF_F000);
            check("frame_dco",         32'(v_dco),  32'h0066_6666);
            check("frame_start_pulse", 32'(v_fs),   32'h0080_0000);
            check("frame_underrun",    32'(v_ur),   e.ur ? 32'h0080_0000 : 32'h0);
            cyc        = -1;
            just_ended = 1'b1;
          end
        end
      end
    end
  end

  // LSB-first instance: expected value is the word in arrival order, first bit as MSB
  initial begin : monitor_lsb
    logic [W-1:0] cap, e;
    forever begin
      @(negedge clk);
      if (!rst && frame_start_l) begin
        if (q_lsb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_lsb_frame: frame_start=1 with no queued word (t=%0t)", $time);
        end else begin
          e   = q_lsb.pop_front();
          cap = '0;
          for (int k = 0; k < 2 * W; k++) begin
            if (k > 0) @(negedge clk);
            if (k % 2 == 0) cap = {cap[W-2:0], dout_l};
          end
          check("lsb_first_order", 32'(cap), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; tx_en = 1'b0; s_valid = 1'b0; s_data = '0;
    tx_en_l = 1'b0; s_valid_l = 1'b0; s_data_l = '0;
    wait_cycles(3);
    check_idle_outputs("reset_hold");
    rst = 1'b0;
    wait_cycles(1);
    check_idle_outputs("after_reset");

    // Single word 12'hA5C; tx_en dropped at b=4 so exactly one frame is sent
    send(12'hA5C, 1'b1);
    s_valid = 1'b0;
    tx_en   = 1'b1;
    wait_frame_start();
    wait_cycles(8);
    tx_en = 1'b0;
    wait_cycles(16);
    check_idle_outputs("after_tx_en_drop");
    wait_cycles(2);

    // Back-to-back stream with s_valid held high
    send(12'h000, 1'b1);
    tx_en = 1'b1;
    send(12'hFFF, 1'b1);
    check("s_ready_low_hold_full", 32'(s_ready), 32'd0);
    send(12'h123, 1'b1);
    check("accept_at_frame_end", 32'(frame_start), 32'd1);
    s_valid = 1'b0;
    wait_frame_start();
    wait_cycles(2);
    tx_en = 1'b0;
    wait_cycles(24);
    check_idle_outputs("after_stream");

    // No input: three idle-word frames, each flagged as underrun
    repeat (3) q.push_back('{word: 12'h800, ur: 1'b1});
    tx_en = 1'b1;
    wait_frame_start();
    wait_cycles(50);
    tx_en = 1'b0;
    wait_cycles(24);
    check_idle_outputs("after_underrun");

    // Reset mid-frame with a second word queued: both must be discarded
    send(12'h3C3, 1'b1);
    tx_en = 1'b1;
    send(12'h5A5, 1'b0);
    s_valid = 1'b0;
    wait_cycles(6);
    rst   = 1'b1;
    tx_en = 1'b0;
    wait_cycles(1);
    check_idle_outputs("in_reset");
    rst = 1'b0;
    wait_cycles(2);
    check_idle_outputs("after_mid_reset");
    q.push_back('{word: 12'h800, ur: 1'b1});
    tx_en = 1'b1;
    wait_frame_start();
    wait_cycles(2);
    tx_en = 1'b0;
    wait_cycles(24);

    // LSB-first instance, word 12'h001: first bit 1, remaining eleven 0
    s_data_l  = 12'h001;
    s_valid_l = 1'b1;
    wait_cycles(1);
    s_valid_l = 1'b0;
    q_lsb.push_back(12'h800);
    tx_en_l = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        seen = frame_start_l;
      end
      check("lsb_frame_start_seen", 32'(seen), 32'd1);
    end
    wait_cycles(2);
    tx_en_l = 1'b0;
    wait_cycles(26);

    check("scoreboard_drained",     32'(q.size()),     32'd0);
    check("lsb_scoreboard_drained", 32'(q_lsb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
